// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and defaults for the pipeline hazard/redirect controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        StRun,
        StMemWait,
        StFlush,
        StWfiDrain,
        StSleep,
        StWake
    } pipe_state_e;

    localparam logic [63:0] WfiStepDefault = 64'd4;

    // Holds FLUSH_CYCLES - 1 for the legal range 1..7.
    localparam int unsigned FlushCntW = 3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: memory-wait stalls, branch redirect + flush, and WFI sleep/wake.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [63:0] WFI_STEP     = WfiStepDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [63:0] ex_pc,
    input  logic        bj_en,
    input  logic [63:0] bj_pc,
    input  logic        load_op,
    input  logic        store_op,
    input  logic        wfi_op,
    input  logic        mem_ready,
    input  logic        irq_pending,
    output logic        stall,
    output logic        flush,
    output logic        redirect_en,
    output logic [63:0] redirect_pc,
    output logic        sleeping,
    output logic [31:0] stall_cycles
);

    localparam logic [FlushCntW-1:0] FlushLoad = FlushCntW'(FLUSH_CYCLES - 1);

    pipe_state_e          state_q, state_d;
    logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
    logic [63:0]          wfi_pc_q, wfi_pc_d;
    logic [63:0]          redirect_pc_q, redirect_pc_d;
    logic                 redirect_en_q, redirect_en_d;
    logic                 mem_op;
    logic                 wake;

    assign mem_op = load_op | store_op;
    assign wake   = ((state_q == StWfiDrain) || (state_q == StSleep)) && irq_pending;

    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        wfi_pc_d      = wfi_pc_q;
        redirect_pc_d = redirect_pc_q;
        redirect_en_d = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        sleeping      = 1'b0;

        unique case (state_q)
            StRun: begin
                // rst_n gates the combinational stall path so it stays low while in reset.
                if (ex_valid && rst_n) begin
                    if (mem_op) begin
                        if (!mem_ready) begin
                            stall   = 1'b1;
                            state_d = StMemWait;
                        end
                    end else if (bj_en) begin
                        redirect_en_d = 1'b1;
                        redirect_pc_d = bj_pc;
                        flush_cnt_d   = FlushLoad;
                        state_d       = StFlush;
                    end else if (wfi_op) begin
                        stall    = 1'b1;
                        wfi_pc_d = ex_pc;
                        state_d  = StWfiDrain;
                    end
                end
            end
            StMemWait: begin
                if (mem_ready) begin
                    state_d = StRun;
                end else begin
                    stall = 1'b1;
                end
            end
            // WAKE is the first flush cycle of the resume redirect.
            StFlush, StWake: begin
                flush = 1'b1;
                if (flush_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - FlushCntW'(1);
                    state_d     = StFlush;
                end
            end
            StWfiDrain: begin
                stall   = 1'b1;
                state_d = StSleep;
            end
            StSleep: begin
                stall    = 1'b1;
                sleeping = 1'b1;
            end
            default: state_d = StRun;
        endcase

        if (wake) begin
            redirect_en_d = 1'b1;
            redirect_pc_d = wfi_pc_q + WFI_STEP;
            flush_cnt_d   = FlushLoad;
            state_d       = StWake;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            flush_cnt_q   <= '0;
            wfi_pc_q      <= '0;
            redirect_pc_q <= '0;
            redirect_en_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            wfi_pc_q      <= wfi_pc_d;
            redirect_pc_q <= redirect_pc_d;
            redirect_en_q <= redirect_en_d;
        end
    end

    assign redirect_en = redirect_en_q;
    assign redirect_pc = redirect_pc_q;

    sat_counter #(
        .WIDTH(32)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (stall),
        .clr  (1'b0),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run vs a cycle model.
module tb_pipe_ctrl;

    localparam int unsigned FLUSH_CYCLES = 2;
    localparam logic [63:0] WFI_STEP     = 64'd4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, bj_en, load_op, store_op, wfi_op, mem_ready, irq_pending;
    logic [63:0] ex_pc, bj_pc;
    logic        stall, flush, redirect_en, sleeping;
    logic [63:0] redirect_pc;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    pipe_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .WFI_STEP    (WFI_STEP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .bj_en       (bj_en),
        .bj_pc       (bj_pc),
        .load_op     (load_op),
        .store_op    (store_op),
        .wfi_op      (wfi_op),
        .mem_ready   (mem_ready),
        .irq_pending (irq_pending),
        .stall       (stall),
        .flush       (flush),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .sleeping    (sleeping),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: what the pipeline is busy with, as plain flags and a flush countdown.
    int              m_flush_left;
    bit              m_mem_wait, m_drain, m_sleep, m_redir;
    logic [63:0]     m_rpc, m_wpc;
    longint unsigned m_cnt;
    logic            e_stall, e_flush, e_sleep;

    function automatic void model_reset();
        m_flush_left = 0;
        m_mem_wait   = 1'b0;
        m_drain      = 1'b0;
        m_sleep      = 1'b0;
        m_redir      = 1'b0;
        m_rpc        = '0;
        m_wpc        = '0;
        m_cnt        = 0;
    endfunction

    function automatic void model_outputs();
        bit idle;
        bit mem;
        idle = (m_flush_left == 0) && !m_mem_wait && !m_drain && !m_sleep;
        mem  = load_op | store_op;
        if (m_mem_wait)                 e_stall = !mem_ready;
        else if (m_drain || m_sleep)    e_stall = 1'b1;
        else if (idle && ex_valid)      e_stall = mem ? !mem_ready : (!bj_en && wfi_op);
        else                            e_stall = 1'b0;
        e_flush = (m_flush_left > 0);
        e_sleep = m_sleep;
    endfunction

    function automatic void model_advance();
        bit wake;
        wake    = 1'b0;
        m_redir = 1'b0;
        if (e_stall && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
        if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (m_mem_wait) begin
            if (mem_ready) m_mem_wait = 1'b0;
        end else if (m_drain) begin
            m_drain = 1'b0;
            if (irq_pending) wake = 1'b1;
            else m_sleep = 1'b1;
        end else if (m_sleep) begin
            if (irq_pending) begin
                m_sleep = 1'b0;
                wake    = 1'b1;
            end
        end else if (ex_valid) begin
            if (load_op || store_op) begin
                if (!mem_ready) m_mem_wait = 1'b1;
            end else if (bj_en) begin
                m_redir      = 1'b1;
                m_rpc        = bj_pc;
                m_flush_left = FLUSH_CYCLES;
            end else if (wfi_op) begin
                m_wpc   = ex_pc;
                m_drain = 1'b1;
            end
        end
        if (wake) begin
            m_redir      = 1'b1;
            m_rpc        = m_wpc + WFI_STEP;
            m_flush_left = FLUSH_CYCLES;
        end
    endfunction

    task automatic idle_inputs();
        ex_valid    = 1'b0;
        load_op     = 1'b0;
        store_op    = 1'b0;
        wfi_op      = 1'b0;
        bj_en       = 1'b0;
        mem_ready   = 1'b0;
        irq_pending = 1'b0;
        ex_pc       = '0;
        bj_pc       = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        ex_valid = 1'b1;
        wfi_op   = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({stall, flush, redirect_en, sleeping} !== 4'b0000 || redirect_pc !== 64'd0 ||
            stall_cycles !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got st/fl/re/sl=%b pc=%h cnt=%0d want 0000 pc=0 cnt=0",
                     {stall, flush, redirect_en, sleeping}, redirect_pc, stall_cycles);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_wait();
        do_reset();
        ex_valid  = 1'b1;
        load_op   = 1'b1;
        ex_pc     = 64'h8000_0010;
        mem_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) mem_ready = 1'b1;
            if (c == 4) idle_inputs();
            #1;
            n_checks++;
            if (stall !== (c < 3)) begin
                n_errors++;
                $display("FAIL load_stall c%0d: got %b want %b", c, stall, (c < 3));
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (stall_cycles !== 32'd3) begin
            n_errors++;
            $display("FAIL load_stall_count: got %0d want 3", stall_cycles);
        end
    endtask

    task automatic test_branch();
        logic [3:0] exp_v [5];
        exp_v = '{4'b0000, 4'b0110, 4'b0100, 4'b1000, 4'b0000};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c == 0) begin
                ex_valid = 1'b1;
                bj_en    = 1'b1;
                bj_pc    = 64'h8000_0100;
            end else if (c == 3) begin
                ex_valid = 1'b1;
                load_op  = 1'b1;
            end else if (c == 4) begin
                mem_ready = 1'b1;
            end
            #1;
            n_checks++;
            if ({stall, flush, redirect_en, sleeping} !== exp_v[c]) begin
                n_errors++;
                $display("FAIL branch c%0d: got st/fl/re/sl=%b want %b",
                         c, {stall, flush, redirect_en, sleeping}, exp_v[c]);
            end
            if (c == 1) begin
                n_checks++;
                if (redirect_pc !== 64'h8000_0100) begin
                    n_errors++;
                    $display("FAIL branch_pc: got %h want 0000000080000100", redirect_pc);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_wfi_sleep();
        logic [3:0] exp_v;
        int         n_sleep;
        n_sleep = 0;
        do_reset();
        for (int c = 0; c < 14; c++) begin
            ex_valid = (c == 0);
            wfi_op   = (c == 0);
            ex_pc    = 64'h8000_0020;
            if (c == 10) irq_pending = 1'b1;
            if (c < 2)        exp_v = 4'b1000;
            else if (c <= 10) exp_v = 4'b1001;
            else if (c == 11) exp_v = 4'b0110;
            else if (c == 12) exp_v = 4'b0100;
            else              exp_v = 4'b0000;
            #1;
            n_checks++;
            if ({stall, flush, redirect_en, sleeping} !== exp_v) begin
                n_errors++;
                $display("FAIL wfi_sleep c%0d: got st/fl/re/sl=%b want %b",
                         c, {stall, flush, redirect_en, sleeping}, exp_v);
            end
            if (sleeping === 1'b1) n_sleep++;
            if (c == 11) begin
                n_checks++;
                if (redirect_pc !== 64'h8000_0024) begin
                    n_errors++;
                    $display("FAIL wfi_resume_pc: got %h want 0000000080000024", redirect_pc);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (n_sleep != 9) begin
            n_errors++;
            $display("FAIL wfi_sleep_len: got %0d want 9", n_sleep);
        end
        idle_inputs();
    endtask

    task automatic test_wfi_irq();
        logic [3:0] exp_v [5];
        exp_v = '{4'b1000, 4'b1000, 4'b0110, 4'b0100, 4'b0000};
        do_reset();
        irq_pending = 1'b1;
        for (int c = 0; c < 5; c++) begin
            ex_valid = (c == 0);
            wfi_op   = (c == 0);
            ex_pc    = 64'h0000_0000_0000_1000;
            #1;
            n_checks++;
            if ({stall, flush, redirect_en, sleeping} !== exp_v[c]) begin
                n_errors++;
                $display("FAIL wfi_irq c%0d: got st/fl/re/sl=%b want %b",
                         c, {stall, flush, redirect_en, sleeping}, exp_v[c]);
            end
            if (c == 2) begin
                n_checks++;
                if (redirect_pc !== 64'h1004) begin
                    n_errors++;
                    $display("FAIL wfi_irq_pc: got %h want 0000000000001004", redirect_pc);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_store_branch();
        logic [3:0] exp_v [5];
        exp_v = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            ex_valid  = (c < 3);
            store_op  = (c < 3);
            bj_en     = (c < 3);
            bj_pc     = 64'hDEAD_BEEF;
            mem_ready = (c == 2);
            #1;
            n_checks++;
            if ({stall, flush, redirect_en, sleeping} !== exp_v[c] || redirect_pc !== 64'd0) begin
                n_errors++;
                $display("FAIL store_branch c%0d: got st/fl/re/sl=%b pc=%h want %b pc=0",
                         c, {stall, flush, redirect_en, sleeping}, redirect_pc, exp_v[c]);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_saturate_reset();
        do_reset();
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        #1;
        n_checks++;
        if (stall_cycles !== 32'hFFFF_FFFE) begin
            n_errors++;
            $display("FAIL sat_preload: got %h want fffffffe", stall_cycles);
        end
        ex_valid  = 1'b1;
        load_op   = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL sat_first: got %h want ffffffff", stall_cycles);
        end
        repeat (2) @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        ex_valid = 1'b1;
        wfi_op   = 1'b1;
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if ({stall, sleeping} !== 2'b11 || stall_cycles !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL sat_hold_sleep: got st/sl=%b cnt=%h want 11 cnt=ffffffff",
                     {stall, sleeping}, stall_cycles);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({stall, flush, redirect_en, sleeping} !== 4'b0000 || redirect_pc !== 64'd0 ||
            stall_cycles !== 32'd0) begin
            n_errors++;
            $display("FAIL sleep_reset: got st/fl/re/sl=%b pc=%h cnt=%h want 0000 pc=0 cnt=0",
                     {stall, flush, redirect_en, sleeping}, redirect_pc, stall_cycles);
        end
        @(negedge clk);
        rst_n       = 1'b1;
        irq_pending = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if ({stall, flush, redirect_en, sleeping} !== 4'b0000 || redirect_pc !== 64'd0) begin
                n_errors++;
                $display("FAIL post_reset_quiet c%0d: got st/fl/re/sl=%b pc=%h want 0000 pc=0",
                         c, {stall, flush, redirect_en, sleeping}, redirect_pc);
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int op;
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            op          = int'($urandom_range(0, 7));
            ex_valid    = ($urandom_range(0, 3) != 0);
            load_op     = (op <= 1);
            store_op    = (op == 2);
            wfi_op      = ($urandom_range(0, 9) == 0);
            bj_en       = ($urandom_range(0, 4) == 0);
            mem_ready   = ($urandom_range(0, 2) != 0);
            irq_pending = ($urandom_range(0, 5) == 0);
            ex_pc       = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFE
                                                      : {$urandom, $urandom};
            bj_pc       = {$urandom, $urandom};
            #1;
            model_outputs();
            n_checks++;
            if ({stall, flush, redirect_en, sleeping} !== {e_stall, e_flush, m_redir, e_sleep} ||
                redirect_pc !== m_rpc || stall_cycles !== 32'(m_cnt)) begin
                n_errors++;
                $display("FAIL random c%0d: got st/fl/re/sl=%b pc=%h cnt=%0d want %b pc=%h cnt=%0d",
                         c, {stall, flush, redirect_en, sleeping}, redirect_pc, stall_cycles,
                         {e_stall, e_flush, m_redir, e_sleep}, m_rpc, m_cnt);
            end
            model_advance();
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_load_wait();
        test_branch();
        test_wfi_sleep();
        test_wfi_irq();
        test_store_branch();
        test_random();
        test_saturate_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
